// File: rtl/fib_checker.sv
// Self-checking sink for a Fibonacci term stream: each term is compared against the sum of the previous two.
// Optional FIB_CHECK_SEED_EN: also require the first two terms after reset to be 0 and 1.
module fib_checker #(
  parameter int WIDTH = 128,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic [CNT_W-1:0] term_count_o,
  output logic             checking_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_index_o,
  output logic [WIDTH-1:0] err_expected_o,
  output logic             wrap_o
);

  // state | meaning
  // EMPTY | no term held since reset
  // ONE   | one term held in prev1
  // RUN   | two terms held, comparing, no mismatch in RUN yet
  // FAIL  | a RUN mismatch was seen; keeps comparing until reset
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    RUN   = 2'd2,
    FAIL  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   prev1_q, prev1_d;
  logic [WIDTH-1:0]   prev2_q, prev2_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               checking_q, checking_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   err_index_q, err_index_d;
  logic [WIDTH-1:0]   err_exp_q, err_exp_d;
  logic               wrap_q, wrap_d;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   exp_cur;
  logic               mismatch;

  assign sum = {1'b0, prev1_q} + {1'b0, prev2_q};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= EMPTY;
      prev1_q     <= '0;
      prev2_q     <= '0;
      cnt_q       <= '0;
      checking_q  <= 1'b0;
      err_q       <= 1'b0;
      err_index_q <= '0;
      err_exp_q   <= '0;
      wrap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev1_q     <= prev1_d;
      prev2_q     <= prev2_d;
      cnt_q       <= cnt_d;
      checking_q  <= checking_d;
      err_q       <= err_d;
      err_index_q <= err_index_d;
      err_exp_q   <= err_exp_d;
      wrap_q      <= wrap_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    prev1_d     = prev1_q;
    prev2_d     = prev2_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    err_index_d = err_index_q;
    err_exp_d   = err_exp_q;
    wrap_d      = wrap_q;
    exp_cur     = '0;
    mismatch    = 1'b0;

    if (in_valid_i) begin
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
      prev1_d = in_data_i;

      case (state_q)
        EMPTY: begin
          state_d = ONE;
`ifdef FIB_CHECK_SEED_EN
          exp_cur  = '0;
          mismatch = (in_data_i != exp_cur);
`endif
        end
        ONE: begin
          state_d = RUN;
          prev2_d = prev1_q;
`ifdef FIB_CHECK_SEED_EN
          exp_cur  = {{(WIDTH-1){1'b0}}, 1'b1};
          mismatch = (in_data_i != exp_cur);
`endif
        end
        default: begin
          prev2_d  = prev1_q;
          exp_cur  = sum[WIDTH-1:0];
          mismatch = (in_data_i != exp_cur);
          // Carry only flags arithmetic overflow; the modulo compare is unaffected.
          if (sum[WIDTH]) begin
            wrap_d = 1'b1;
          end
          if (mismatch) begin
            state_d = FAIL;
          end
        end
      endcase

      if (mismatch && !err_q) begin
        err_d       = 1'b1;
        err_index_d = cnt_q;
        err_exp_d   = exp_cur;
      end
    end

    checking_d = (state_d == RUN) || (state_d == FAIL);
  end

  assign term_count_o   = cnt_q;
  assign checking_o     = checking_q;
  assign err_o          = err_q;
  assign err_index_o    = err_index_q;
  assign err_expected_o = err_exp_q;
  assign wrap_o         = wrap_q;

endmodule

// File: tb/tb_fib_checker.sv
// Directed bench for fib_checker: clean/injected streams, gaps, async reset, wrap, long run, saturation.
module tb_fib_checker;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] in_data;
  logic [31:0]  term_count;
  logic         checking;
  logic         err;
  logic [31:0]  err_index;
  logic [127:0] err_expected;
  logic         wrap;

  logic         s_valid;
  logic [15:0]  s_data;
  logic [3:0]   s_count;
  logic         s_checking;
  logic         s_err;
  logic [3:0]   s_index;
  logic [15:0]  s_expected;
  logic         s_wrap;

  int checks = 0;
  int errors = 0;

  fib_checker #(.WIDTH(128), .CNT_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_data_i(in_data),
    .term_count_o(term_count), .checking_o(checking), .err_o(err),
    .err_index_o(err_index), .err_expected_o(err_expected), .wrap_o(wrap)
  );

  fib_checker #(.WIDTH(16), .CNT_W(4)) dut_small (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(s_valid), .in_data_i(s_data),
    .term_count_o(s_count), .checking_o(s_checking), .err_o(s_err),
    .err_index_o(s_index), .err_expected_o(s_expected), .wrap_o(s_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic feed(input logic [127:0] val, input logic vld);
    @(negedge clk);
    in_valid = vld;
    in_data  = val;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_count"}, {96'd0, term_count}, 128'd0);
    check({tag, "_checking"}, {127'd0, checking}, 128'd0);
    check({tag, "_err"}, {127'd0, err}, 128'd0);
    check({tag, "_index"}, {96'd0, err_index}, 128'd0);
    check({tag, "_expected"}, err_expected, 128'd0);
    check({tag, "_wrap"}, {127'd0, wrap}, 128'd0);
  endtask

  logic [127:0] half;
  logic [127:0] m1, m2, term;
  logic [128:0] wide;
  logic         wrap_m;
  logic [15:0]  a16, b16, t16;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    s_valid  = 1'b0;
    s_data   = '0;
    half     = {1'b1, 127'd0};
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Clean sequence
    feed(128'd0, 1'b1);
    check("clean_chk_after1", {127'd0, checking}, 128'd0);
    feed(128'd1, 1'b1);
    check("clean_chk_after2", {127'd0, checking}, 128'd1);
    feed(128'd1, 1'b1);
    feed(128'd2, 1'b1);
    feed(128'd3, 1'b1);
    feed(128'd5, 1'b1);
    feed(128'd8, 1'b1);
    feed(128'd13, 1'b1);
    check("clean_count", {96'd0, term_count}, 128'd8);
    check("clean_err", {127'd0, err}, 128'd0);
    check("clean_wrap", {127'd0, wrap}, 128'd0);
    check("clean_checking", {127'd0, checking}, 128'd1);

    // Injected error at index 4
    do_reset();
    feed(128'd0, 1'b1);
    feed(128'd1, 1'b1);
    feed(128'd1, 1'b1);
    feed(128'd2, 1'b1);
    check("inj_err_before", {127'd0, err}, 128'd0);
    feed(128'd4, 1'b1);
    check("inj_err", {127'd0, err}, 128'd1);
    check("inj_index", {96'd0, err_index}, 128'd4);
    check("inj_expected", err_expected, 128'd3);
    feed(128'd5, 1'b1);
    feed(128'd9, 1'b1);
    check("inj_err_held", {127'd0, err}, 128'd1);
    check("inj_index_held", {96'd0, err_index}, 128'd4);
    check("inj_expected_held", err_expected, 128'd3);
    check("inj_count", {96'd0, term_count}, 128'd7);

    // Gaps, then asynchronous reset mid-cycle
    do_reset();
    feed(128'd0, 1'b1);
    feed(128'd77, 1'b0);
    feed(128'd99, 1'b0);
    check("gap_count_hold", {96'd0, term_count}, 128'd1);
    check("gap_chk_hold", {127'd0, checking}, 128'd0);
    feed(128'd1, 1'b1);
    feed(128'd1, 1'b1);
    check("gap_count", {96'd0, term_count}, 128'd3);
    check("gap_err", {127'd0, err}, 128'd0);
    check("gap_checking", {127'd0, checking}, 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    feed(128'd5, 1'b1);
    feed(128'd8, 1'b1);
    feed(128'd13, 1'b1);
    check("refeed_count", {96'd0, term_count}, 128'd3);
`ifdef FIB_CHECK_SEED_EN
    check("refeed_err", {127'd0, err}, 128'd1);
`else
    check("refeed_err", {127'd0, err}, 128'd0);
`endif
    check("refeed_index", {96'd0, err_index}, 128'd0);
    check("refeed_expected", err_expected, 128'd0);

    // Wrapped sum is not an error
    do_reset();
    feed(half, 1'b1);
    feed(half, 1'b1);
    check("wrap_before", {127'd0, wrap}, 128'd0);
    feed(128'd0, 1'b1);
    check("wrap_set", {127'd0, wrap}, 128'd1);
`ifdef FIB_CHECK_SEED_EN
    check("wrap_err", {127'd0, err}, 128'd1);
`else
    check("wrap_err", {127'd0, err}, 128'd0);
`endif

    // Wrap and first mismatch on the same edge
    do_reset();
    feed(half, 1'b1);
    feed(half, 1'b1);
    feed(128'd5, 1'b1);
    check("wrapmis_wrap", {127'd0, wrap}, 128'd1);
    check("wrapmis_err", {127'd0, err}, 128'd1);
`ifdef FIB_CHECK_SEED_EN
    check("wrapmis_index", {96'd0, err_index}, 128'd0);
    check("wrapmis_expected", err_expected, 128'd0);
`else
    check("wrapmis_index", {96'd0, err_index}, 128'd2);
    check("wrapmis_expected", err_expected, 128'd0);
`endif

    // Long generator-style run with a 129-bit reference model for wrap
    do_reset();
    m1 = '0;
    m2 = '0;
    wrap_m = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (i == 0) term = 128'd0;
      else if (i == 1) term = 128'd1;
      else begin
        wide = {1'b0, m1} + {1'b0, m2};
        term = wide[127:0];
        if (wide[128]) wrap_m = 1'b1;
      end
      feed(term, 1'b1);
      check("run_wrap", {127'd0, wrap}, {127'd0, wrap_m});
      m2 = m1;
      m1 = term;
    end
    check("run_err", {127'd0, err}, 128'd0);
    check("run_count", {96'd0, term_count}, 128'd500);
    check("run_wrap_final", {127'd0, wrap}, 128'd1);

    // Counter saturation on the narrow instance
    do_reset();
    a16 = 16'd0;
    b16 = 16'd1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = a16;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      t16 = a16 + b16;
      a16 = b16;
      b16 = t16;
      if (i == 14) check("sat_count_15", {124'd0, s_count}, 128'd15);
    end
    check("sat_count_hold", {124'd0, s_count}, 128'd15);
    check("sat_err", {127'd0, s_err}, 128'd0);
    check("sat_checking", {127'd0, s_checking}, 128'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
